// File: rtl/sort_5_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sort_5_stream_ctrl_if
// Brief    : Input and output valid/ready streams of the 5-word sort controller.
// Revision : 1.0 - initial release
// ============================================================================
interface sort_5_stream_ctrl_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // Controller side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/sort_5_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sort_5_stream_ctrl
// Brief    : Gathers up to five words, sorts them in one cycle through an
//            embedded 9-comparator network, then replays them on a stream.
//            Define SORT_CTRL_DESC_EN to replay in descending order.
// Revision : 1.0 - initial release
// ============================================================================
module sort_5_stream_ctrl #(
    parameter logic [31:0] PAD_VALUE = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                rst,
    sort_5_stream_ctrl_if.slave bus,
    output logic                busy,
    output logic [15:0]         batch_count
);

    localparam int c_N = 5;
    localparam int c_NET_A [9] = '{0, 3, 2, 2, 0, 0, 1, 1, 1};
    localparam int c_NET_B [9] = '{1, 4, 4, 3, 3, 2, 4, 3, 2};

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_slot   [c_N];
    logic [31:0] r_result [c_N];
    logic [2:0]  r_cnt;
    logic [2:0]  r_idx;
    logic [15:0] r_batch_count;
    logic [31:0] w_net    [c_N];
    logic [31:0] w_tmp;
    logic        w_in_hs;
    logic        w_out_hs;
    logic        w_last;
    logic [2:0]  w_idx_start;
    logic [2:0]  w_idx_next;

    assign w_in_hs  = (r_state == ST_FILL) && bus.in_valid;
    assign w_out_hs = (r_state == ST_DRAIN) && bus.out_ready;

`ifdef SORT_CTRL_DESC_EN
    assign w_idx_start = r_cnt - 3'd1;
    assign w_idx_next  = r_idx - 3'd1;
    assign w_last      = (r_idx == 3'd0);
`else
    assign w_idx_start = 3'd0;
    assign w_idx_next  = r_idx + 3'd1;
    assign w_last      = (r_idx == r_cnt - 3'd1);
`endif

    // Unfilled slots take PAD_VALUE so they settle at the top and are never replayed.
    always_comb begin
        w_tmp = '0;
        for (int i = 0; i < c_N; i++) begin
            w_net[i] = (i < int'(r_cnt)) ? r_slot[i] : PAD_VALUE;
        end
        for (int s = 0; s < 9; s++) begin
            if (w_net[c_NET_A[s]] > w_net[c_NET_B[s]]) begin
                w_tmp             = w_net[c_NET_A[s]];
                w_net[c_NET_A[s]] = w_net[c_NET_B[s]];
                w_net[c_NET_B[s]] = w_tmp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_in_hs && ((r_cnt == 3'd4) || bus.in_last)) begin
                    w_state_nxt = ST_SORT;
                end
            end
            ST_SORT:  w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (w_out_hs && w_last) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default:  w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= 3'd0;
            r_idx         <= 3'd0;
            r_batch_count <= 16'd0;
            for (int i = 0; i < c_N; i++) begin
                r_slot[i]   <= 32'd0;
                r_result[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_in_hs) begin
                        r_slot[r_cnt] <= bus.in_data;
                        r_cnt         <= r_cnt + 3'd1;
                    end
                end
                ST_SORT: begin
                    for (int i = 0; i < c_N; i++) begin
                        r_result[i] <= w_net[i];
                    end
                    r_idx <= w_idx_start;
                end
                ST_DRAIN: begin
                    if (w_out_hs) begin
                        if (w_last) begin
                            r_cnt         <= 3'd0;
                            r_batch_count <= r_batch_count + 16'd1;
                        end else begin
                            r_idx <= w_idx_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags decode the registered state only; no path from in_valid/out_ready.
    assign bus.in_ready  = (r_state == ST_FILL);
    assign bus.out_valid = (r_state == ST_DRAIN);
    assign bus.out_data  = (r_state == ST_DRAIN) ? r_result[r_idx] : 32'd0;
    assign bus.out_last  = (r_state == ST_DRAIN) && w_last;
    assign busy          = (r_state != ST_FILL);
    assign batch_count   = r_batch_count;

endmodule
`default_nettype wire
